fifo_drain: RTL and testbench

Read-side controller for the shift-register FIFO whose occupancy is tracked by the push/pop pointer counter. It watches the FIFO occupancy and issues `pop` strobes. Captured words go into a 2-entry output buffer and are presented on a valid/ready stream toward the downstream consumer. Draining starts only once a threshold occupancy is reached, or on an explicit flush, so downstream sees bursts rather than single trickling words.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/drain_skid.sv | 71 +++++++
 rtl/fifo_drain.sv | 93 +++++++++
 tb/tb_fifo_drain.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared types and constants for the FIFO read-side drain logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  localparam int DELIV_W = 16;

endpackage

`default_nettype wire

// File: rtl/drain_skid.sv
// ============================================================================
// Module   : drain_skid
// Purpose  : Two-entry in-order output buffer feeding a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module drain_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_occ;
  logic             w_rd;
  logic             w_wr;

  assign rd_valid = (r_occ != 2'd0);
  assign rd_data  = r_head;
  assign occ      = r_occ;
  assign w_rd     = rd_valid && rd_ready;
  // A write into a full buffer is only accepted when a read frees a slot.
  assign w_wr     = wr && ((r_occ != 2'd2) || w_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({w_wr, w_rd})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= wr_data;
          end else begin
            r_tail <= wr_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
          end
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= wr_data;
          end else begin
            r_head <= r_tail;
            r_tail <= wr_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_drain.sv
// ============================================================================
// Module   : fifo_drain
// Purpose  : Threshold/flush-triggered burst drain of a FIFO into a stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 8,
  parameter int THRESHOLD = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DEPTH-1:0]   fifo_count,
  input  logic [WIDTH-1:0]   fifo_dout,
  output logic               pop,
  input  logic               flush,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic [DELIV_W-1:0] delivered
);

  localparam logic [DEPTH-1:0] c_thresh = DEPTH'(THRESHOLD);
  localparam logic [DEPTH-1:0] c_one    = DEPTH'(1);

  drain_state_t       r_state;
  drain_state_t       w_state_next;
  logic [1:0]         w_occ;
  logic               w_fifo_nz;
  logic [DELIV_W-1:0] r_delivered;

  assign w_fifo_nz = (fifo_count != '0);
  // Pop depends only on registered state and FIFO occupancy, never on m_ready.
  assign pop       = (r_state == DRAIN) && w_fifo_nz && (w_occ != 2'd2);
  assign busy      = (r_state == DRAIN) || (w_occ != 2'd0);
  assign delivered = r_delivered;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if ((fifo_count >= c_thresh) || (flush && w_fifo_nz)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_fifo_nz || ((fifo_count == c_one) && pop)) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_delivered <= '0;
    end else if (m_valid && m_ready) begin
      r_delivered <= r_delivered + 1'b1;
    end
  end

  drain_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .wr       (pop),
    .wr_data  (fifo_dout),
    .rd_valid (m_valid),
    .rd_ready (m_ready),
    .rd_data  (m_data),
    .occ      (w_occ)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain.sv
// ============================================================================
// Module   : tb_fifo_drain
// Purpose  : Directed, table-driven self-checking bench for fifo_drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifo_count;
  logic [7:0]  fifo_dout;
  logic        pop;
  logic        flush;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic [15:0] delivered;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  cnt;
    logic [7:0]  dout;
    logic        fl;
    logic        rdy;
    logic        e_pop;
    logic        e_mv;
    logic        chk_md;
    logic [7:0]  e_md;
    logic        e_busy;
    logic [15:0] e_dlv;
  } vec_t;

  vec_t tbl[$];

  fifo_drain #(
    .DEPTH     (4),
    .WIDTH     (8),
    .THRESHOLD (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_count (fifo_count),
    .fifo_dout  (fifo_dout),
    .pop        (pop),
    .flush      (flush),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .delivered  (delivered)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input bit rst, input int cnt, input int dout, input bit fl,
                             input bit rdy, input bit p, input bit mv, input bit cm,
                             input int md, input bit b, input int d);
    vec_t r;
    r.rst = rst;  r.cnt = 4'(cnt); r.dout = 8'(dout); r.fl = fl; r.rdy = rdy;
    r.e_pop = p;  r.e_mv = mv;     r.chk_md = cm;     r.e_md = 8'(md);
    r.e_busy = b; r.e_dlv = 16'(d);
    return r;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;

    // Burst start: A, B, C with m_ready high
    tbl.push_back(v(0,1,'hA1,0,1, 0,0,0,'h00,0,0));
    tbl.push_back(v(0,1,'hA1,0,1, 0,0,0,'h00,0,0));
    tbl.push_back(v(0,3,'hA1,0,1, 0,0,0,'h00,0,0));
    tbl.push_back(v(0,3,'hA1,0,1, 1,0,0,'h00,1,0));
    tbl.push_back(v(0,2,'hB2,0,1, 1,1,1,'hA1,1,0));
    tbl.push_back(v(0,1,'hC3,0,1, 1,1,1,'hB2,1,1));
    tbl.push_back(v(0,0,'h00,0,1, 0,1,1,'hC3,1,2));
    tbl.push_back(v(0,0,'h00,0,1, 0,0,0,'h00,0,3));
    tbl.push_back(v(1,0,'h00,0,0, 0,0,1,'h00,0,0));
    // Backpressure: two pops then stall with head held
    tbl.push_back(v(0,3,'h11,0,0, 0,0,0,'h00,0,0));
    tbl.push_back(v(0,3,'h11,0,0, 1,0,0,'h00,1,0));
    tbl.push_back(v(0,2,'h22,0,0, 1,1,1,'h11,1,0));
    tbl.push_back(v(0,1,'h33,0,0, 0,1,1,'h11,1,0));
    tbl.push_back(v(0,1,'h33,0,0, 0,1,1,'h11,1,0));
    tbl.push_back(v(0,1,'h33,0,1, 0,1,1,'h11,1,0));
    tbl.push_back(v(0,1,'h33,0,1, 1,1,1,'h22,1,1));
    tbl.push_back(v(0,0,'h00,0,1, 0,1,1,'h33,1,2));
    tbl.push_back(v(0,0,'h00,0,1, 0,0,0,'h00,0,3));
    tbl.push_back(v(1,0,'h00,0,0, 0,0,1,'h00,0,0));
    // Flush with one word, then flush on an empty FIFO
    tbl.push_back(v(0,1,'hD4,0,1, 0,0,0,'h00,0,0));
    tbl.push_back(v(0,1,'hD4,1,1, 0,0,0,'h00,0,0));
    tbl.push_back(v(0,1,'hD4,0,1, 1,0,0,'h00,1,0));
    tbl.push_back(v(0,0,'h00,0,1, 0,1,1,'hD4,1,0));
    tbl.push_back(v(0,0,'h00,0,1, 0,0,0,'h00,0,1));
    tbl.push_back(v(0,0,'h00,1,1, 0,0,0,'h00,0,1));
    tbl.push_back(v(0,0,'h00,0,1, 0,0,0,'h00,0,1));
    // Reset while the buffer holds two words
    tbl.push_back(v(0,3,'h55,0,0, 0,0,0,'h00,0,1));
    tbl.push_back(v(0,3,'h55,0,0, 1,0,0,'h00,1,1));
    tbl.push_back(v(0,2,'h66,0,0, 1,1,1,'h55,1,1));
    tbl.push_back(v(0,1,'h77,0,0, 0,1,1,'h55,1,1));
    tbl.push_back(v(1,1,'h77,0,0, 0,0,1,'h00,0,0));
    tbl.push_back(v(0,1,'h77,0,0, 0,0,0,'h00,0,0));

    reset = 1'b1; fifo_count = '0; fifo_dout = '0; flush = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("reset pop", pop, 0);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_data", m_data, 0);
    chk("reset busy", busy, 0);
    chk("reset delivered", delivered, 0);

    // Occupancy below threshold never starts a burst
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = 1'b0; fifo_count = 4'd1; fifo_dout = 8'h99; m_ready = 1'b1;
      #1;
      chk($sformatf("below%0d pop", i), pop, 0);
      chk($sformatf("below%0d m_valid", i), m_valid, 0);
      chk($sformatf("below%0d busy", i), busy, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; fifo_count = tbl[i].cnt; fifo_dout = tbl[i].dout;
      flush = tbl[i].fl;  m_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d pop", i), pop, tbl[i].e_pop);
      chk($sformatf("row%0d m_valid", i), m_valid, tbl[i].e_mv);
      chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("row%0d delivered", i), delivered, tbl[i].e_dlv);
      if (tbl[i].chk_md) chk($sformatf("row%0d m_data", i), m_data, tbl[i].e_md);
    end

    // Counter wrap: 65535 handshakes, then one more
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_count = '0;
    @(negedge clk);
    reset = 1'b0; fifo_count = 4'd3; fifo_dout = 8'h5A;
    n = 0; cyc = 0;
    while (n < 65535 && cyc < 70000) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid) n++;
      cyc++;
    end
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("wrap handshakes issued", n, 65535);
    chk("wrap delivered ffff", delivered, 16'hFFFF);
    @(negedge clk);
    fifo_count = '0;
    #1;
    chk("wrap m_valid before last", m_valid, 1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("wrap delivered 0000", delivered, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
